blockram_byte_fifo: RTL and testbench

- First-word-fall-through byte FIFO controller built around one 512x8 simple dual-port block RAM (BlockRAM8R_8W).
- Buffers bytes between a producer and a consumer in the same clock domain, e.g. SPI receive data toward the cartridge-bus register interface.
- Owns read/write pointers, occupancy and the RAM's one-cycle read latency.
- Presents valid/ready on both sides with sustained 1 byte/cycle throughput.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/BlockRAM8R_8W.sv | 32 +++
 rtl/blockram_byte_fifo.sv | 130 +++++++++++++
 tb/tb_blockram_byte_fifo.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing and types for the block-RAM byte FIFO.
package fifo_pkg;

    localparam int FifoDepthLog2 = 9;
    localparam int FifoDepth     = 512;

    typedef logic [FifoDepthLog2-1:0] ptr_t;
    typedef logic [FifoDepthLog2:0]   count_t;

endpackage

// File: rtl/BlockRAM8R_8W.sv
// 512x8 simple dual-port RAM: one write port, one registered read port.
module BlockRAM8R_8W
    import fifo_pkg::*;
(
    input  logic       read_clk_i,
    input  logic       read_enable_i,
    input  ptr_t       read_addr_i,
    output logic [7:0] read_data_o,
    input  logic       write_clk_i,
    input  logic       write_enable_i,
    input  ptr_t       write_addr_i,
    input  logic [7:0] write_data_i
);

    logic [7:0] mem [FifoDepth];
    logic [7:0] read_data_q;

    always_ff @(posedge write_clk_i) begin
        if (write_enable_i) begin
            mem[write_addr_i] <= write_data_i;
        end
    end

    always_ff @(posedge read_clk_i) begin
        if (read_enable_i) begin
            read_data_q <= mem[read_addr_i];
        end
    end

    assign read_data_o = read_data_q;

endmodule

// File: rtl/blockram_byte_fifo.sv
// First-word-fall-through byte FIFO: block RAM storage plus a 2-entry output stage
// that hides the RAM's one-cycle read latency.
module blockram_byte_fifo
    import fifo_pkg::*;
#(
    parameter int AlmostFullLevel  = 480,
    parameter int AlmostEmptyLevel = 32
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       flush_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_data_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o,
    output count_t     count_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       almost_full_o,
    output logic       almost_empty_o
);

    ptr_t       wptr_q, wptr_d, rptr_q, rptr_d;
    count_t     count_q, count_d, unread_q, unread_d;
    logic [1:0] occ_q, occ_d, busy;
    logic       inflight_q, inflight_d;
    logic [7:0] head_q, head_d, second_q, second_d;
    logic       empty_q, empty_d, full_q, full_d;
    logic       afull_q, afull_d, aempty_q, aempty_d;
    logic       push, pop, read_en;
    logic [7:0] ram_rdata;

    assign push    = in_valid_i & ~full_q & ~flush_i;
    assign pop     = (occ_q != 2'd0) & out_ready_i & ~flush_i;
    assign busy    = occ_q + {1'b0, inflight_q};
    // A read may be issued into a full stage only when the head leaves this cycle.
    assign read_en = ~flush_i & (unread_q != '0) &
                     ((busy < 2'd2) | ((busy == 2'd2) & pop));

    BlockRAM8R_8W u_ram (
        .read_clk_i     (clk_i),
        .read_enable_i  (read_en),
        .read_addr_i    (rptr_q),
        .read_data_o    (ram_rdata),
        .write_clk_i    (clk_i),
        .write_enable_i (push),
        .write_addr_i   (wptr_q),
        .write_data_i   (in_data_i)
    );

    always_comb begin
        wptr_d     = wptr_q + {8'd0, push};
        rptr_d     = rptr_q + {8'd0, read_en};
        count_d    = count_q + {9'd0, push} - {9'd0, pop};
        unread_d   = unread_q + {9'd0, push} - {9'd0, read_en};
        inflight_d = read_en;
        head_d     = head_q;
        second_d   = second_q;
        occ_d      = occ_q;
        if (pop) begin
            head_d = second_q;
            occ_d  = occ_q - 2'd1;
        end
        // Returning data joins behind whatever survives the pop.
        if (inflight_q) begin
            if (occ_d == 2'd0) begin
                head_d = ram_rdata;
            end else begin
                second_d = ram_rdata;
            end
            occ_d = occ_d + 2'd1;
        end
        if (flush_i) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            unread_d   = '0;
            inflight_d = 1'b0;
            head_d     = 8'd0;
            second_d   = 8'd0;
            occ_d      = 2'd0;
        end
        empty_d  = (count_d == '0);
        full_d   = (count_d == count_t'(FifoDepth));
        afull_d  = (count_d >= count_t'(AlmostFullLevel));
        aempty_d = (count_d <= count_t'(AlmostEmptyLevel));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            unread_q   <= '0;
            inflight_q <= 1'b0;
            head_q     <= 8'd0;
            second_q   <= 8'd0;
            occ_q      <= 2'd0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            unread_q   <= unread_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            second_q   <= second_d;
            occ_q      <= occ_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
        end
    end

    assign in_ready_o     = ~full_q;
    assign out_valid_o    = (occ_q != 2'd0);
    assign out_data_o     = head_q;
    assign count_o        = count_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;

endmodule

// File: tb/tb_blockram_byte_fifo.sv
// Scoreboard bench: accepted pushes queue expected bytes, a negedge monitor checks pops and flags.
module tb_blockram_byte_fifo;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       flush_i = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [7:0] in_data_i = 8'd0;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic [7:0] out_data_o;
    logic [9:0] count_o;
    logic       empty_o, full_o, almost_full_o, almost_empty_o;

    int         checks = 0;
    int         passed = 0;
    logic [7:0] exp_q[$];
    int         model_cnt = 0;
    logic       push_s, pop_s;

    always #5 clk = ~clk;

    blockram_byte_fifo #(
        .AlmostFullLevel  (480),
        .AlmostEmptyLevel (32)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_data_i      (in_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .count_o        (count_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int k;
        for (k = 0; k < budget && !empty_o; k++) tick();
        check(name, 32'(empty_o), 1);
    endtask

    // Monitor: compare DUT against the reference queue/count just before each edge.
    always @(negedge clk) begin
        if (reset_i) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            check("count", 32'(count_o), model_cnt);
            check("empty", 32'(empty_o), 32'(model_cnt == 0));
            check("full", 32'(full_o), 32'(model_cnt == 512));
            check("almost_full", 32'(almost_full_o), 32'(model_cnt >= 480));
            check("almost_empty", 32'(almost_empty_o), 32'(model_cnt <= 32));
            check("in_ready", 32'(in_ready_o), 32'(model_cnt != 512));
            if (flush_i) begin
                exp_q.delete();
                model_cnt = 0;
            end else begin
                push_s = in_valid_i && in_ready_o;
                pop_s  = out_valid_o && out_ready_i;
                if (out_valid_o) check("valid_has_data", 32'(exp_q.size() != 0), 1);
                if (pop_s && exp_q.size() != 0) check("out_data", 32'(out_data_o), 32'(exp_q.pop_front()));
                if (push_s) exp_q.push_back(in_data_i);
                model_cnt = model_cnt + int'(push_s) - int'(pop_s);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_count", 32'(count_o), 0);
        check("rst_empty", 32'(empty_o), 1);
        check("rst_full", 32'(full_o), 0);
        check("rst_afull", 32'(almost_full_o), 0);
        check("rst_aempty", 32'(almost_empty_o), 1);
        check("rst_in_ready", 32'(in_ready_o), 1);
        check("rst_out_valid", 32'(out_valid_o), 0);
        check("rst_out_data", 32'(out_data_o), 0);
        reset_i = 1'b0;
        $display("txn reset: done");

        // Single byte latency
        in_valid_i = 1'b1; in_data_i = 8'h11;
        tick();
        in_valid_i = 1'b0;
        check("lat_count", 32'(count_o), 1);
        check("lat_empty", 32'(empty_o), 0);
        check("lat_valid_n0", 32'(out_valid_o), 0);
        tick();
        check("lat_valid_n1", 32'(out_valid_o), 0);
        tick();
        check("lat_valid_n2", 32'(out_valid_o), 1);
        check("lat_data", 32'(out_data_o), 32'h11);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("lat_drained", 32'(empty_o), 1);
        $display("txn single: byte 0x11 pushed and popped");

        // Fill to 512, refused 513th, push+pop at full, drain
        for (int i = 0; i < 512; i++) begin
            in_valid_i = 1'b1; in_data_i = 8'(i);
            tick();
        end
        in_valid_i = 1'b0;
        check("fill_count", 32'(count_o), 512);
        check("fill_full", 32'(full_o), 1);
        check("fill_in_ready", 32'(in_ready_o), 0);
        check("fill_afull", 32'(almost_full_o), 1);
        in_valid_i = 1'b1; in_data_i = 8'hEE;
        tick();
        in_valid_i = 1'b0;
        check("over_count", 32'(count_o), 512);
        in_valid_i = 1'b1; in_data_i = 8'hDD; out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        check("fullpp_count", 32'(count_o), 511);
        check("fullpp_in_ready", 32'(in_ready_o), 1);
        out_ready_i = 1'b1;
        wait_empty("fill_drain", 600);
        out_ready_i = 1'b0;
        $display("txn fill: 512 bytes filled and drained");

        // Continuous streaming
        out_ready_i = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            in_valid_i = 1'b1; in_data_i = 8'(i * 7 + 3);
            tick();
            if (i >= 3) begin
                check("stream_valid", 32'(out_valid_o), 1);
                check("stream_count", 32'(count_o), 3);
            end
        end
        in_valid_i = 1'b0;
        wait_empty("stream_drain", 20);
        out_ready_i = 1'b0;
        $display("txn stream: 2000 bytes at full rate");

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            in_valid_i  = 1'($urandom_range(0, 1));
            in_data_i   = 8'($urandom);
            out_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        wait_empty("random_drain", 600);
        out_ready_i = 1'b0;
        $display("txn random: 10000 cycles");

        // Flush with count 37, a read in flight and a coincident push
        for (int i = 0; i < 38; i++) begin
            in_valid_i = 1'b1; in_data_i = 8'(i + 8'h40);
            tick();
        end
        in_valid_i = 1'b0;
        repeat (3) tick();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("pre_flush_count", 32'(count_o), 37);
        flush_i = 1'b1; in_valid_i = 1'b1; in_data_i = 8'h77;
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        check("flush_count", 32'(count_o), 0);
        check("flush_valid", 32'(out_valid_o), 0);
        repeat (2) tick();
        check("flush_no_stale", 32'(out_valid_o), 0);
        in_valid_i = 1'b1; in_data_i = 8'hA5;
        tick();
        in_valid_i = 1'b0;
        for (int k = 0; k < 10 && !out_valid_o; k++) tick();
        check("post_flush_valid", 32'(out_valid_o), 1);
        check("post_flush_data", 32'(out_data_o), 32'hA5);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("post_flush_empty", 32'(empty_o), 1);
        $display("txn flush: 0xA5 emerged first after flush");

        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
